rr_stream_mux: RTL and testbench
================================

# rr_stream_mux

Parametrised N-input, WIDTH-bit registered stream multiplexer with valid/ready handshaking and a selectable arbitration mode: fixed select (driven by a `sel` port) or round-robin across requesting inputs. It is the successor to the combinational 4:1 16-bit data mux in the datapath. It merges several producer streams, such as FP unit result ports, into one consumer, with a single output register that holds each beat until the consumer accepts it. It sustains one beat per cycle.

## Interface
- `WIDTH`, 16: data width per channel.
- `N`, 4: number of input channels, ≥2.
- `RR`, 1: 1 = round-robin arbitration, 0 = fixed select by `sel`.
- `SW`, `$clog2(N)`: select/channel-index width (derived, not overridden).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready; combinational.
- `sel`  in  SW  channel select, used only when RR=0.
- `out_data`  out  WIDTH  registered output data.
- `out_chan`  out  SW  index of the channel that produced `out_data`.
- `out_valid`  out  1  registered output valid.
- `out_ready`  in  1  consumer ready.

## Operation
- **Load condition:** `load = !out_valid || out_ready`, meaning the output register is empty or is being drained this cycle.
- **Grant with RR=0:** the grant goes to `sel`. If `sel` ≥ N, nothing is granted.
- **Grant with RR=1:** the grant goes to the first asserted `in_valid` found scanning from index `(last+1) mod N` upward with wrap-around. `last` is the index of the most recently accepted channel.
- **Ready:** `in_ready[i] = load && grant==i`. At most one bit of `in_ready` is high. `in_ready` may be high while `in_valid` is low. It depends only on `out_valid`, `out_ready`, `sel`, `in_valid` and `last`, never on the selected channel's data.
- **Transfer:** an input transfer occurs when `in_valid[g] && in_ready[g]`. On the next edge:
  - `out_data <= in_data[g]`, `out_chan <= g`, `out_valid <= 1`.
  - With RR=1, `last <= g`.
- **Drain:** if `out_valid && out_ready` and no input transfer occurs, `out_valid <= 0`. `out_data` and `out_chan` keep their values.
- **Stall:** if `out_valid && !out_ready`, `out_data`, `out_chan`, `out_valid` and `last` all hold. No input is accepted.
- **Simultaneous drain and transfer:** the register is overwritten with the new beat and `out_valid` stays 1. No bubble is inserted.
- **Starvation:** with RR=1, `last` advances only on accepted transfers. Any channel held valid is therefore served within N accepted beats.
- **Input protocol:** inputs must hold `in_data` stable while valid and not accepted. The block does not check this.

## Timing
- **Reset values:** `out_valid=0`, `out_data=0`, `out_chan=0`, `last=N-1`, so channel 0 has first priority after reset. `in_ready` therefore equals the grant decode immediately after reset.
- **Reset mid-operation:** asynchronous assertion clears all state at once. A beat held in the output register is dropped. Deassertion is synchronised externally.
- **Latency:** 1 cycle from input acceptance to `out_valid`.
- **Throughput:** 1 beat/cycle while `out_ready` is held high.
- **Combinational paths:** `out_ready` → `in_ready`, and `in_valid` → `in_ready` (RR=1 priority scan). There is no combinational path from `in_data` to any output.

## Test plan
- **Reset:** assert `reset_n`=0 mid-transfer → `out_valid`=0, `out_data`=0, `out_chan`=0 immediately. After release, all `in_valid` high with `out_ready`=1 (RR=1) → first grant goes to ch0.
- **Round-robin sweep:** RR=1, N=4, all four valid with data 16'h1000+i, `out_ready`=1 → `out_chan` sequence 0,1,2,3,0 on consecutive cycles. `out_data` is 16'h1000..16'h1003 then 16'h1000, with no bubbles.
- **Skip idle channels:** RR=1, only ch1 and ch3 valid → `out_chan` alternates 1,3,1,3. `in_ready[0]` and `in_ready[2]` are never high together with an acceptance.
- **Backpressure:** `out_valid`=1 holding 16'hBEEF and `out_ready`=0 for 5 cycles → `out_data` stays 16'hBEEF and `in_ready`=0 throughout. When `out_ready` rises, the next beat appears on the following cycle.
- **Fixed select:** RR=0, `sel`=2, all valid, `in_data[2]`=16'h00A5 → only `in_ready[2]` is high and `out_data`=16'h00A5, `out_chan`=2. Switching `sel` to 3 mid-stream → the next accepted beat comes from ch3.
- **Drain/empty:** single beat on ch0, then all `in_valid`=0 with `out_ready`=1 → `out_valid` drops after one cycle. `out_data` retains its last value.

Source files
------------

// File: rtl/rr_stream_mux.sv
// N-input registered stream multiplexer with valid/ready handshaking.
// Arbitration is either a fixed select (sel) or round-robin over requesting inputs.
module rr_stream_mux #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int RR    = 1,
    parameter int SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SW-1:0]      sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [SW-1:0]    last;
    logic [SW-1:0]    rr_grant;
    logic             rr_found;
    logic [SW-1:0]    grant;
    logic             grant_vld;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;

    assign load = !out_valid || out_ready;

    // Scan upward from the channel after the last accepted one, wrapping around.
    always_comb begin
        int idx;
        rr_found = 1'b0;
        rr_grant = '0;
        idx      = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!rr_found && in_valid[idx[SW-1:0]]) begin
                rr_found = 1'b1;
                rr_grant = idx[SW-1:0];
            end
        end
    end

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        if (RR != 0) begin
            grant     = rr_grant;
            grant_vld = rr_found;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i)) begin
                    grant     = sel;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_vld && grant == SW'(i)) begin
                in_ready[i] = load;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(in_ready & in_valid);

    // A new beat overwrites the register even while the old one drains, so no bubble appears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            last      <= SW'(N - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_chan  <= grant;
            if (RR != 0) begin
                last <= grant;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Drives a round-robin and a fixed-select instance with shared inputs and
// compares both against a queue-free behavioural model of the merge rules.
module tb_rr_stream_mux;

    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int SW    = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [SW-1:0]      sel;
    logic               out_ready;

    logic [N-1:0]       rr_in_ready,  fx_in_ready;
    logic [WIDTH-1:0]   rr_out_data,  fx_out_data;
    logic [SW-1:0]      rr_out_chan,  fx_out_chan;
    logic               rr_out_valid, fx_out_valid;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] chan_data [N];

    // Model state, index 0 = round-robin instance, index 1 = fixed-select instance
    bit               m_ov [2];
    logic [WIDTH-1:0] m_od [2];
    int               m_oc [2];
    int               m_last;

    always #5 clk = ~clk;

    rr_stream_mux #(.WIDTH(WIDTH), .N(N), .RR(1)) dut_rr (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (rr_in_ready),
        .sel       (sel),
        .out_data  (rr_out_data),
        .out_chan  (rr_out_chan),
        .out_valid (rr_out_valid),
        .out_ready (out_ready)
    );

    rr_stream_mux #(.WIDTH(WIDTH), .N(N), .RR(0)) dut_fx (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (fx_in_ready),
        .sel       (sel),
        .out_data  (fx_out_data),
        .out_chan  (fx_out_chan),
        .out_valid (fx_out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ov[d] = 1'b0;
            m_od[d] = '0;
            m_oc[d] = 0;
        end
        m_last = N - 1;
    endtask

    // Channel the arbiter should pick right now, or -1 when none is granted.
    function automatic int pick(input bit rr);
        int c;
        if (!rr) return int'(sel);
        for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input int d);
        int g;
        g = pick(d == 0);
        if ((m_ov[d] && !out_ready) || g < 0) return '0;
        return N'(1 << g);
    endfunction

    task automatic check_output(input string tag);
        check({tag, ".rr_valid"}, 32'(rr_out_valid), 32'(m_ov[0]));
        check({tag, ".rr_data"},  32'(rr_out_data),  32'(m_od[0]));
        check({tag, ".rr_chan"},  32'(rr_out_chan),  32'(m_oc[0]));
        check({tag, ".rr_ready"}, 32'(rr_in_ready),  32'(exp_ready(0)));
        check({tag, ".fx_valid"}, 32'(fx_out_valid), 32'(m_ov[1]));
        check({tag, ".fx_data"},  32'(fx_out_data),  32'(m_od[1]));
        check({tag, ".fx_chan"},  32'(fx_out_chan),  32'(m_oc[1]));
        check({tag, ".fx_ready"}, 32'(fx_in_ready),  32'(exp_ready(1)));
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model at the edge.
    task automatic apply_stimulus(input string tag, input logic [N-1:0] v,
                                  input logic [SW-1:0] s, input bit ordy);
        bit               n_ov [2];
        logic [WIDTH-1:0] n_od [2];
        int               n_oc [2];
        int               n_last;
        int               g;
        in_valid  = v;
        sel       = s;
        out_ready = ordy;
        in_data   = {chan_data[3], chan_data[2], chan_data[1], chan_data[0]};
        #1;
        check_output(tag);
        n_last = m_last;
        for (int d = 0; d < 2; d++) begin
            n_ov[d] = m_ov[d];
            n_od[d] = m_od[d];
            n_oc[d] = m_oc[d];
            g = pick(d == 0);
            if ((!m_ov[d] || ordy) && g >= 0 && v[g]) begin
                n_ov[d] = 1'b1;
                n_od[d] = chan_data[g];
                n_oc[d] = g;
                if (d == 0) n_last = g;
            end else if (ordy) begin
                n_ov[d] = 1'b0;
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            m_ov[d] = n_ov[d];
            m_od[d] = n_od[d];
            m_oc[d] = n_oc[d];
        end
        m_last = n_last;
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        sel       = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) chan_data[i] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.rr_valid", 32'(rr_out_valid), 32'd0);
        check("reset.fx_ready", 32'(fx_in_ready), 32'h1);
        reset_n = 1'b1;
        $display("[TB] reset released");

        // Round-robin sweep with every channel requesting
        for (int i = 0; i < N; i++) chan_data[i] = 16'h1000 + 16'(i);
        for (int i = 0; i < 6; i++) apply_stimulus("sweep", 4'hF, 2'd0, 1'b1);
        check("sweep.chan_after5", 32'(rr_out_chan), 32'd1);

        // Only ch1 and ch3 requesting
        for (int i = 0; i < 5; i++) apply_stimulus("skip", 4'b1010, 2'd0, 1'b1);

        // Backpressure with BEEF held in the output register
        chan_data[0] = 16'hBEEF;
        apply_stimulus("bp_load", 4'b0001, 2'd0, 1'b1);
        chan_data[0] = 16'h1111;
        for (int i = 0; i < 5; i++) apply_stimulus("bp_hold", 4'hF, 2'd0, 1'b0);
        check("bp.rr_data", 32'(rr_out_data), 32'hBEEF);
        for (int i = 0; i < 2; i++) apply_stimulus("bp_release", 4'hF, 2'd0, 1'b1);

        // Fixed select, then switch mid-stream
        chan_data[2] = 16'h00A5;
        chan_data[3] = 16'h0033;
        apply_stimulus("fix2", 4'hF, 2'd2, 1'b1);
        check("fix2.fx_data", 32'(fx_out_data), 32'h00A5);
        apply_stimulus("fix2b", 4'hF, 2'd2, 1'b1);
        apply_stimulus("fix3", 4'hF, 2'd3, 1'b1);
        check("fix3.fx_chan", 32'(fx_out_chan), 32'd3);

        // Single beat then drain to empty
        chan_data[0] = 16'h0C0C;
        apply_stimulus("drain_beat", 4'b0001, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) apply_stimulus("drain_idle", 4'b0000, 2'd1, 1'b1);

        // Asynchronous reset while a beat is held
        apply_stimulus("rst_load", 4'hF, 2'd1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst.rr_valid", 32'(rr_out_valid), 32'd0);
        check("rst.rr_data",  32'(rr_out_data),  32'd0);
        check("rst.rr_chan",  32'(rr_out_chan),  32'd0);
        check("rst.fx_valid", 32'(fx_out_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply_stimulus("post_rst", 4'hF, 2'd1, 1'b1);
        check("post_rst.rr_chan", 32'(rr_out_chan), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < N; c++) chan_data[c] = 16'($urandom);
            apply_stimulus("random", 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                           $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
